// File: rtl/board_tile_renderer.sv
// Sequences a full 4x4 board redraw: background fill per tile, then a fixed
// window of the selected glyph drawer, with its pixel stream forwarded to VGA.
module board_tile_renderer #(
    parameter int          TILE_SIZE    = 30,
    parameter int          GRID_X0      = 20,
    parameter int          GRID_Y0      = 0,
    parameter int          GLYPH_CYCLES = 111,
    parameter logic [2:0]  BG_COLOUR    = 3'b111,
    parameter logic [2:0]  EMPTY_COLOUR = 3'b000,
    parameter logic [2:0]  FG_COLOUR    = 3'b000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [63:0] board,
    output logic        busy,
    output logic        done,
    output logic [7:0]  tile_x,
    output logic [6:0]  tile_y,
    output logic [3:0]  glyph_sel,
    output logic        glyph_en,
    output logic        glyph_rst_n,
    input  logic [7:0]  glyph_x_in,
    input  logic [6:0]  glyph_y_in,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot
);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_GRST, S_GLYPH, S_NEXT, S_DONE
    } state_t;

    localparam logic [4:0] FX_LAST = 5'(TILE_SIZE - 1);
    localparam logic [6:0] G_LAST  = 7'(GLYPH_CYCLES - 1);
    localparam logic [7:0] X0      = 8'(GRID_X0);
    localparam logic [6:0] Y0      = 7'(GRID_Y0);
    localparam logic [7:0] TS8     = 8'(TILE_SIZE);
    localparam logic [6:0] TS7     = 7'(TILE_SIZE);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [4:0]  fx_q, fx_d, fy_q, fy_d;
    logic [6:0]  gcnt_q, gcnt_d;
    logic [63:0] snap_q, snap_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            gcnt_q  <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            gcnt_q  <= gcnt_d;
            snap_q  <= snap_d;
        end
    end

    // Tile origin and value are pure functions of the index, so they hold
    // steady for the whole tile.
    assign tile_x    = X0 + TS8 * {6'd0, idx_q[1:0]};
    assign tile_y    = Y0 + TS7 * {5'd0, idx_q[3:2]};
    assign glyph_sel = snap_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        gcnt_d  = gcnt_q;
        snap_d  = snap_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d  = board;
                    idx_d   = '0;
                    fx_d    = '0;
                    fy_d    = '0;
                    gcnt_d  = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (fx_q == FX_LAST) begin
                    fx_d = '0;
                    fy_d = fy_q + 5'd1;
                    if (fy_q == FX_LAST) begin
                        fy_d    = '0;
                        state_d = (glyph_sel == 4'd0) ? S_NEXT : S_GRST;
                    end
                end else begin
                    fx_d = fx_q + 5'd1;
                end
            end
            S_GRST: begin
                gcnt_d  = '0;
                state_d = S_GLYPH;
            end
            S_GLYPH: begin
                gcnt_d = gcnt_q + 7'd1;
                if (gcnt_q == G_LAST) begin
                    gcnt_d  = '0;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                fx_d   = '0;
                fy_d   = '0;
                gcnt_d = '0;
                if (idx_q == 4'd15) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_FILL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        glyph_en   = 1'b0;
        vga_plot   = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        unique case (state_q)
            S_FILL: begin
                busy       = 1'b1;
                vga_plot   = 1'b1;
                vga_x      = tile_x + {3'd0, fx_q};
                vga_y      = tile_y + {2'd0, fy_q};
                vga_colour = (glyph_sel == 4'd0) ? EMPTY_COLOUR : BG_COLOUR;
            end
            S_GLYPH: begin
                busy       = 1'b1;
                glyph_en   = 1'b1;
                vga_plot   = 1'b1;
                vga_x      = glyph_x_in;
                vga_y      = glyph_y_in;
                vga_colour = FG_COLOUR;
            end
            S_GRST, S_NEXT: busy = 1'b1;
            S_DONE:         done = 1'b1;
            default: ;
        endcase
    end

    assign glyph_rst_n = resetn & (state_q != S_GRST);

endmodule

// File: tb/tb_board_tile_renderer.sv
// Bench for board_tile_renderer: per-cycle scoreboard of expected outputs built
// from a behavioural board walk, driven by a small table of boards.
module tb_board_tile_renderer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [63:0] board;
    logic        busy, done, glyph_en, glyph_rst_n, vga_plot;
    logic [7:0]  tile_x, vga_x, glyph_x_in;
    logic [6:0]  tile_y, vga_y, glyph_y_in;
    logic [3:0]  glyph_sel;
    logic [2:0]  vga_colour;

    board_tile_renderer dut (
        .clk(clk), .resetn(resetn), .start(start), .board(board),
        .busy(busy), .done(done), .tile_x(tile_x), .tile_y(tile_y),
        .glyph_sel(glyph_sel), .glyph_en(glyph_en), .glyph_rst_n(glyph_rst_n),
        .glyph_x_in(glyph_x_in), .glyph_y_in(glyph_y_in),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy, done, plot, gen, grst, pass;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic [7:0] tx;
        logic [6:0] ty;
        logic [3:0] sel;
    } exp_t;

    typedef struct {
        logic [63:0] board;
        int          done_cyc;
        bit          disturb;
    } vec_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic build(input logic [63:0] b);
        exp_t e;
        logic [3:0] v;
        logic [7:0] tx;
        logic [6:0] ty;
        for (int t = 0; t < 16; t++) begin
            v  = b[4*t +: 4];
            tx = 8'(20 + (t % 4) * 30);
            ty = 7'(0 + (t / 4) * 30);
            for (int fy = 0; fy < 30; fy++)
                for (int fx = 0; fx < 30; fx++) begin
                    e = '0;
                    e.busy = 1; e.plot = 1; e.grst = 1;
                    e.x = tx + 8'(fx); e.y = ty + 7'(fy);
                    e.col = (v == 0) ? 3'b000 : 3'b111;
                    e.tx = tx; e.ty = ty; e.sel = v;
                    exp_q.push_back(e);
                end
            if (v != 0) begin
                e = '0; e.busy = 1; e.grst = 0; e.tx = tx; e.ty = ty; e.sel = v;
                exp_q.push_back(e);
                for (int g = 0; g < 111; g++) begin
                    e = '0; e.busy = 1; e.plot = 1; e.gen = 1; e.grst = 1; e.pass = 1;
                    e.col = 3'b000; e.tx = tx; e.ty = ty; e.sel = v;
                    exp_q.push_back(e);
                end
            end
            e = '0; e.busy = 1; e.grst = 1; e.tx = tx; e.ty = ty; e.sel = v;
            exp_q.push_back(e);
        end
        e = '0; e.done = 1; e.grst = 1;
        exp_q.push_back(e);
        e = '0; e.grst = 1;
        exp_q.push_back(e);
    endtask

    task automatic check_cycle(input exp_t e, input int cyc);
        exp_t a;
        a = '0;
        a.busy = busy; a.done = done; a.plot = vga_plot; a.gen = glyph_en;
        a.grst = glyph_rst_n; a.pass = e.pass;
        a.x = vga_x; a.y = vga_y; a.col = vga_colour;
        if (e.pass) begin
            e.x = glyph_x_in;
            e.y = glyph_y_in;
        end
        if (e.busy) begin
            a.tx = tile_x; a.ty = tile_y; a.sel = glyph_sel;
        end
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL cycle %0d: got %h expected %h", cyc, a, e);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic run(input vec_t v);
        exp_t e;
        int   cyc, done_at;
        build(v.board);
        @(negedge clk);
        board = v.board;
        start = 1'b1;
        cyc = 0;
        done_at = -1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (v.disturb && cyc == 3 * 1013 + 100) begin
                board = ~board;
                start = 1'b1;
            end
            glyph_x_in = 8'($urandom);
            glyph_y_in = 7'($urandom);
            #1;
            e = exp_q.pop_front();
            check_cycle(e, cyc);
            if (done === 1'b1 && done_at < 0) done_at = cyc;
        end
        start = 1'b0;
        check_val("done_cycle", done_at, v.done_cyc);
    endtask

    vec_t vecs[4];

    initial begin
        resetn = 1'b0; start = 1'b1; board = '1;
        glyph_x_in = '0; glyph_y_in = '0;

        // reset held with start asserted
        repeat (3) begin
            @(negedge clk); #1;
            check_val("reset_outputs",
                      {busy, done, vga_plot, glyph_en, glyph_rst_n, tile_x, tile_y, vga_x, vga_y, vga_colour, glyph_sel},
                      {5'b00000, 8'd20, 7'd0, 8'd0, 7'd0, 3'd0, 4'd0});
        end
        @(negedge clk);
        resetn = 1'b1; start = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            check_val("idle_after_reset", {busy, vga_plot, glyph_en, glyph_rst_n}, 4'b0001);
        end

        vecs[0] = '{64'h0, 14417, 1'b0};
        vecs[1] = '{64'h6, 14529, 1'b0};
        vecs[2] = '{64'h0FED_CBA9_8765_4321, 16097, 1'b1};
        vecs[3] = '{64'h0000_0100_00F0_0000, 14641, 1'b0};
        for (int i = 0; i < 4; i++) run(vecs[i]);

        // drop reset mid-glyph
        @(negedge clk);
        board = 64'h6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (900 + 1 + 50 - 1) @(negedge clk);
        #1;
        check_val("in_glyph", {glyph_en, vga_plot, busy}, 3'b111);
        resetn = 1'b0;
        @(negedge clk); #1;
        check_val("glyph_reset", {busy, vga_plot, glyph_en, glyph_rst_n, done, vga_x, tile_x},
                  {5'b00000, 8'd0, 8'd20});
        resetn = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            check_val("idle_after_glyph_reset", {busy, vga_plot, glyph_en, glyph_rst_n}, 4'b0001);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/board_tile_renderer.md
Name: board_tile_renderer

Overview:
Upstream sequencer for the per-digit glyph drawers. On start it walks the 4x4 sliding-puzzle board row-major. For each tile it fills a background square, then runs the selected glyph drawer for a fixed window and forwards that drawer's pixel stream to the VGA adapter. It drives the glyph drawer's tile origin, select, enable and synchronous reset, and owns the VGA plot/colour port.

Parameters:
TILE_SIZE, 30, tile edge in pixels (square)
GRID_X0, 20, x origin of tile 0
GRID_Y0, 0, y origin of tile 0
GLYPH_CYCLES, 111, cycles a glyph drawer runs per tile
BG_COLOUR, 3'b111, fill colour of numbered tiles
EMPTY_COLOUR, 3'b000, fill colour of the empty tile (value 0)
FG_COLOUR, 3'b000, glyph stroke colour

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
start  in  1  request full-board redraw; sampled only in IDLE
board  in  64  tile i = board[4i+3:4i]; 0 = empty, 1..15 = number
busy  out  1  high from the first FILL cycle until done
done  out  1  one-cycle pulse when the board is finished
tile_x  out  8  current tile origin x, to glyph drawer xIn
tile_y  out  7  current tile origin y, to glyph drawer yIn
glyph_sel  out  4  current tile value; selects the drawer
glyph_en  out  1  enable to the glyph drawer
glyph_rst_n  out  1  synchronous active-low reset to the glyph drawer
glyph_x_in  in  8  absolute pixel x from the selected drawer
glyph_y_in  in  7  absolute pixel y from the selected drawer
vga_x  out  8  pixel x
vga_y  out  7  pixel y
vga_colour  out  3  pixel colour
vga_plot  out  1  write strobe

Behaviour:
- Reset, and resetn low in any state, gives:
  - state IDLE, tile index 0, all counters 0, snapshot 0.
  - busy, done, vga_plot, glyph_en = 0; vga_x, vga_y, vga_colour = 0; glyph_sel 0.
  - tile_x = GRID_X0, tile_y = GRID_Y0; glyph_rst_n = 0 while resetn low.
- Tile origin for index i: x = GRID_X0 + (i%4)*TILE_SIZE, y = GRID_Y0 + (i/4)*TILE_SIZE. Arithmetic is 8-bit for x and 7-bit for y. Parameters must keep all pixels below 256/128; no wrap handling.
- glyph_sel equals the snapshot value of the current tile; tile_x, tile_y and glyph_sel are stable for the tile's whole duration.
- State machine:
  - IDLE: busy 0. If start=1, latch board into the snapshot, set index 0, fx = fy = 0, go to FILL. A start pulse in any other state is ignored. Board changes after latching are ignored.
  - FILL: vga_plot 1, vga_x = tile_x+fx, vga_y = tile_y+fy. Colour is BG_COLOUR, or EMPTY_COLOUR if the value is 0. fx increments each cycle; at TILE_SIZE-1 it clears and fy increments. This gives TILE_SIZE² cycles, 900 by default. After the pixel (TILE_SIZE-1, TILE_SIZE-1): go to NEXT if the value is 0, else GLYPH_RST.
  - GLYPH_RST: 1 cycle, glyph_rst_n 0, glyph_en 0, plot 0.
  - GLYPH: glyph_en 1 and vga_plot 1 for exactly GLYPH_CYCLES cycles, counted by gcnt 0..GLYPH_CYCLES-1. vga_x/y pass glyph_x_in/glyph_y_in through combinationally; colour FG_COLOUR. Then go to NEXT.
  - NEXT: 1 cycle, plot 0, glyph_en 0. If index = 15, go to DONE; else increment the index, clear fx/fy/gcnt, go to FILL.
  - DONE: done 1, busy 0, plot 0 for one cycle, then IDLE.
- Output timing: VGA outputs are a combinational decode of the registered state and counters, so there is no added latency.
- Outside FILL and GLYPH: vga_plot 0 and vga_x, vga_y, vga_colour are 0.
- glyph_rst_n = resetn AND NOT GLYPH_RST.
- Cycle budget: numbered tile 900+1+111+1 = 1013 cycles; empty tile 900+1 = 901 cycles.
- Counters: fx and fy are 5 bits; gcnt is 7 bits. All are wide enough for the defaults.

Test Plan:
- Reset: hold resetn low 3 cycles with start=1 -> busy 0, plot 0, glyph_rst_n 0, tile_x 20, tile_y 0; no redraw begins until resetn high and start is sampled in IDLE.
- All-zero board, start pulse -> every tile uses EMPTY_COLOUR, glyph_en never asserted. Exactly 16*901 plot/gap cycles, then done pulses on cycle 14417 after start.
- board = 64'h6 (tile 0 = 6):
  - First plots are (20,0),(21,0),…; the last fill pixel is (49,29).
  - Then glyph_rst_n is low for 1 cycle, then glyph_en and plot are high 111 cycles with glyph_sel 6 and vga_x/y equal to glyph_x_in/glyph_y_in.
  - Tile 1 then starts at (50,0).
- Full board (tile i = i+1, tile 15 = 0):
  - tile 15 fill starts at (110,90) and ends at (139,119) with EMPTY_COLOUR.
  - done arrives on cycle 15*1013+901+1 = 16097.
- Mid-run robustness:
  - Change board and pulse start during FILL of tile 3 -> both ignored, and the snapshot values are still drawn.
  - Drop resetn during GLYPH -> next cycle IDLE, plot 0, busy 0.
